// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-low, ordered a..g from MSB to LSB.
package sevenseg_pkg;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef struct packed {
        logic [3:0] val;
        logic       dp;
        logic       blank;
    } digit_entry_t;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational decoder from one stored digit entry to active-low cathodes.
// Bit 7 is the decimal point; blanking overrides everything.
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  digit_entry_t entry_i,
    output logic [7:0]   cathode_n_o
);

    always_comb begin
        cathode_n_o = SEG_BLANK;
        if (!entry_i.blank) begin
            cathode_n_o = {~entry_i.dp, SEG_HEX[entry_i.val]};
        end
    end

endmodule

// File: rtl/sevenseg_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver with per-digit storage,
// round-robin scanning and PWM brightness gating within each digit slot.
module sevenseg_scan_mux
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 400000,
    parameter int DIM_BITS    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_idx,
    input  logic [3:0]                    wr_data,
    input  logic                          wr_dp,
    input  logic                          wr_blank,
    input  logic [DIM_BITS-1:0]           brightness,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic [7:0]                    cathode_n,
    output logic [4*NUM_DIGITS-1:0]       digits_q,
    output logic                          slot_start
);

    localparam int IDX_W     = $clog2(NUM_DIGITS);
    localparam int PHASE_LEN = SLOT_CYCLES >> DIM_BITS;
    localparam int SLOT_W    = $clog2(SLOT_CYCLES);
    localparam int PCNT_W    = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;

    digit_entry_t          entry_q [NUM_DIGITS];
    logic [SLOT_W-1:0]     slot_cnt_q,  slot_cnt_d;
    logic [PCNT_W-1:0]     phase_cnt_q, phase_cnt_d;
    logic [DIM_BITS-1:0]   phase_q,     phase_d;
    logic [IDX_W-1:0]      scan_idx_q,  scan_idx_d;
    logic [DIM_BITS-1:0]   bright_q,    bright_d;
    logic [NUM_DIGITS-1:0] anode_q,     anode_d;
    logic [7:0]            cathode_q,   cathode_d;
    logic                  slot_start_q, slot_start_d;

    logic         slot_wrap;
    logic         phase_wrap;
    logic         slot_load;
    logic         wr_in_range;
    logic [7:0]   dec_cathode;
    digit_entry_t sel_entry;

    assign wr_in_range = ({1'b0, wr_idx} < (IDX_W + 1)'(NUM_DIGITS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                entry_q[i] <= '0;
            end
        end else if (wr_en && wr_in_range) begin
            entry_q[wr_idx] <= digit_entry_t'{val: wr_data, dp: wr_dp, blank: wr_blank};
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_readback
        assign digits_q[4*g +: 4] = entry_q[g].val;
    end

    assign sel_entry = entry_q[scan_idx_q];

    sevenseg_decode u_decode (
        .entry_i     (sel_entry),
        .cathode_n_o (dec_cathode)
    );

    // Outputs are registered from the current counter state, so the anode
    // switch-over and the new cathodes land on the same edge.
    always_comb begin
        slot_wrap    = (slot_cnt_q == SLOT_W'(SLOT_CYCLES - 1));
        phase_wrap   = (phase_cnt_q == PCNT_W'(PHASE_LEN - 1));
        slot_load    = (slot_cnt_q == '0);

        slot_cnt_d   = slot_wrap  ? '0 : slot_cnt_q + SLOT_W'(1);
        phase_cnt_d  = phase_wrap ? '0 : phase_cnt_q + PCNT_W'(1);
        phase_d      = phase_wrap ? phase_q + DIM_BITS'(1) : phase_q;

        scan_idx_d   = scan_idx_q;
        if (slot_wrap) begin
            scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
        end

        bright_d     = slot_load ? brightness  : bright_q;
        cathode_d    = slot_load ? dec_cathode : cathode_q;
        slot_start_d = slot_load;

        anode_d      = '1;
        if (phase_q <= bright_d) begin
            anode_d[scan_idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_q   <= '0;
            phase_cnt_q  <= '0;
            phase_q      <= '0;
            scan_idx_q   <= '0;
            bright_q     <= '0;
            anode_q      <= '1;
            cathode_q    <= SEG_BLANK;
            slot_start_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            phase_cnt_q  <= phase_cnt_d;
            phase_q      <= phase_d;
            scan_idx_q   <= scan_idx_d;
            bright_q     <= bright_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
            slot_start_q <= slot_start_d;
        end
    end

    assign anode_n    = anode_q;
    assign cathode_n  = cathode_q;
    assign slot_start = slot_start_q;

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Scoreboard bench: the driver queues the expected picture of each slot,
// the monitor checks anode/cathode/lit-cycle count whenever a slot starts.
module tb_sevenseg_scan_mux;

    typedef struct {
        logic [3:0] anode;
        logic [7:0] cathode;
        int         lit;
        bit         full;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [3:0]  wr_data;
    logic        wr_dp;
    logic        wr_blank;
    logic [1:0]  brightness;
    logic [3:0]  anode_n;
    logic [7:0]  cathode_n;
    logic [15:0] digits_q;
    logic        slot_start;

    logic        wr2_en;
    logic [1:0]  wr2_idx;
    logic [3:0]  wr2_data;
    logic [2:0]  anode2_n;
    logic [7:0]  cathode2_n;
    logic [11:0] digits2_q;
    logic        slot2_start;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    always #5 clk = ~clk;

    sevenseg_scan_mux #(.NUM_DIGITS(4), .SLOT_CYCLES(16), .DIM_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .wr_dp(wr_dp), .wr_blank(wr_blank),
        .brightness(brightness), .anode_n(anode_n), .cathode_n(cathode_n),
        .digits_q(digits_q), .slot_start(slot_start)
    );

    // Three-digit instance so an out-of-range index fits in the index port.
    sevenseg_scan_mux #(.NUM_DIGITS(3), .SLOT_CYCLES(8), .DIM_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr2_en), .wr_idx(wr2_idx),
        .wr_data(wr2_data), .wr_dp(1'b0), .wr_blank(1'b0),
        .brightness(1'b1), .anode_n(anode2_n), .cathode_n(cathode2_n),
        .digits_q(digits2_q), .slot_start(slot2_start)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit second, input logic [1:0] idx,
                                 input logic [3:0] data, input logic dp,
                                 input logic blank);
        if (second) begin
            wr2_en = 1'b1; wr2_idx = idx; wr2_data = data;
        end else begin
            wr_en = 1'b1; wr_idx = idx; wr_data = data; wr_dp = dp; wr_blank = blank;
        end
        @(negedge clk);
        wr_en  = 1'b0;
        wr2_en = 1'b0;
    endtask

    task automatic waitSlotStart();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!slot_start && n < 40);
        if (!slot_start) begin
            checks++;
            errors++;
            $display("[TB] FAIL slot_start timeout: got 0 after %0d cycles, expected 1", n);
        end
    endtask

    task automatic pushSlot(input logic [3:0] an, input logic [7:0] cat,
                            input int lit, input bit full);
        exp_t e;
        e.anode = an; e.cathode = cat; e.lit = lit; e.full = full;
        expQ.push_back(e);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " anode_n"},    32'(anode_n),    32'hF);
        checkOutput({tag, " cathode_n"},  32'(cathode_n),  32'hFF);
        checkOutput({tag, " slot_start"}, 32'(slot_start), 32'h0);
        checkOutput({tag, " digits_q"},   32'(digits_q),   32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        int   n, lit;
        bit   stable, oneHot;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && slot_start && !done) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected slot: got slot_start with empty queue, expected none");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("slot anode_n",   32'(anode_n),   32'(e.anode));
                    checkOutput("slot cathode_n", 32'(cathode_n), 32'(e.cathode));
                    lit    = (anode_n != 4'hF) ? 1 : 0;
                    stable = 1'b1;
                    oneHot = ($countones(~anode_n) <= 1);
                    n      = 1;
                    while (n < 16) begin
                        @(posedge clk);
                        #1;
                        if (!rst_n) break;
                        if (anode_n != 4'hF) lit++;
                        if (cathode_n !== e.cathode) stable = 1'b0;
                        if ($countones(~anode_n) > 1) oneHot = 1'b0;
                        n++;
                    end
                    if (n == 16) begin
                        checkOutput("slot lit cycles",    32'(lit),    32'(e.lit));
                        checkOutput("cathode held",       32'(stable), 32'h1);
                        checkOutput("single anode low",   32'(oneHot), 32'h1);
                    end else if (e.full) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL slot cut short: got %0d cycles, expected 16", n);
                    end
                end
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; wr_dp = 1'b0;
        wr_blank = 1'b0; brightness = 2'd3;
        wr2_en = 1'b0; wr2_idx = '0; wr2_data = '0;

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");

        pushSlot(4'hE, 8'h81, 16, 1'b1);
        pushSlot(4'hD, 8'h81, 16, 1'b1);
        pushSlot(4'hB, 8'h81, 16, 1'b1);
        pushSlot(4'h7, 8'h81, 16, 1'b1);
        rst_n = 1'b1;
        repeat (4) waitSlotStart();

        pushSlot(4'hE, 8'h81, 16, 1'b1);
        pushSlot(4'hD, 8'h81,  4, 1'b1);
        pushSlot(4'hB, 8'h08,  4, 1'b1);
        pushSlot(4'h7, 8'h81, 16, 1'b1);
        pushSlot(4'hE, 8'h81, 16, 1'b1);
        pushSlot(4'hD, 8'hFF, 16, 1'b1);
        pushSlot(4'hB, 8'h08, 16, 1'b1);
        pushSlot(4'h7, 8'h81, 16, 1'b0);

        waitSlotStart();
        @(negedge clk);
        applyStimulus(1'b0, 2'd2, 4'hA, 1'b1, 1'b0);
        checkOutput("digits_q after idx2 write", 32'(digits_q), 32'h0A00);
        brightness = 2'd0;

        waitSlotStart();
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 2'd1, 4'h3, 1'b0, 1'b1);
        checkOutput("digits_q after idx1 write", 32'(digits_q), 32'h0A30);

        waitSlotStart();
        repeat (3) @(negedge clk);
        brightness = 2'd3;

        repeat (3) waitSlotStart();
        applyStimulus(1'b1, 2'd3, 4'h9, 1'b0, 1'b0);
        checkOutput("out-of-range write ignored", 32'(digits2_q), 32'h000);
        applyStimulus(1'b1, 2'd2, 4'h5, 1'b0, 1'b0);
        checkOutput("in-range write small bank", 32'(digits2_q), 32'h500);

        waitSlotStart();
        waitSlotStart();
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkResetOutputs("mid-slot reset");
        pushSlot(4'hE, 8'h81, 16, 1'b1);
        pushSlot(4'hD, 8'h81, 16, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        waitSlotStart();
        waitSlotStart();
        repeat (15) @(negedge clk);
        done = 1'b1;
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
